// File: rtl/lsu_trigger_ctl.sv
// LSU trigger controller: CSR-held trigger configuration, dc3->dc5 hit qualification and breakpoint/halt sequencing.
// Define LSU_TRIG_COUNT_EN to add the per-trigger tcount hit counters.
module lsu_trigger_ctl #(
    parameter int NUM_TRIG = 4,
    parameter int CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    csr_wr_en,
    input  logic                    csr_rd_en,
    input  logic [1:0]              csr_tsel,
    input  logic [1:0]              csr_reg,
    input  logic [31:0]             csr_wdata,
    output logic [31:0]             csr_rdata,
    input  logic                    dbg_mode,
    input  logic                    dbg_halt_ack,
    input  logic [NUM_TRIG-1:0]     lsu_trigger_match_dc3,
    input  logic                    flush_dc4,
    input  logic                    flush_dc5,
    output logic [NUM_TRIG-1:0]     trig_select,
    output logic [NUM_TRIG-1:0]     trig_match,
    output logic [NUM_TRIG-1:0]     trig_store,
    output logic [NUM_TRIG-1:0]     trig_load,
    output logic [32*NUM_TRIG-1:0]  trig_tdata2,
    output logic [NUM_TRIG-1:0]     trig_hit_dc5,
    output logic                    trig_brkpt_dc5,
    output logic                    trig_halt_req
);
    localparam int LOAD_B   = 0;
    localparam int STORE_B  = 1;
    localparam int M_B      = 6;
    localparam int MATCH_B  = 7;
    localparam int CHAIN_B  = 11;
    localparam int ACTION_B = 12;
    localparam int SELECT_B = 19;
    localparam int HIT_B    = 20;
    localparam int DMODE_B  = 27;

    localparam logic [31:0] WR_MASK    = 32'h0818_18C3;
    localparam logic [31:0] DMODE_MASK = 32'h0800_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HALT_REQ = 2'd1,
        HALTED   = 2'd2
    } state_e;

    state_e              state_q;
    logic                haltReq_q;
    logic                dbgMode_q;
    logic [NUM_TRIG-1:0] dc4_q;
    logic [NUM_TRIG-1:0] dc5_q;

    logic [31:0] tdata1_q [NUM_TRIG];
    logic [31:0] tdata1_d [NUM_TRIG];
    logic [31:0] tdata2_q [NUM_TRIG];
    logic [31:0] tdata2_d [NUM_TRIG];
    logic [CNT_W-1:0] tcountView [NUM_TRIG];

    logic                idle;
    logic                wrAllowed;
    logic                haltCommit;
    logic [NUM_TRIG-1:0] qualRaw;
    logic [NUM_TRIG-1:0] qual;
    logic [NUM_TRIG-1:0] commitRaw;
    logic [NUM_TRIG-1:0] cntGate;
    logic [NUM_TRIG-1:0] hitVec;
    logic [NUM_TRIG-1:0] actionVec;

    assign idle = (state_q == IDLE);

    // A trigger owned by debug mode (dmode=1) is locked against writes from normal mode.
    always_comb begin
        wrAllowed = 1'b0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (csr_wr_en && int'(csr_tsel) == i) begin
                wrAllowed = dbg_mode | ~tdata1_q[i][DMODE_B];
            end
        end
    end

    always_comb begin
        trig_select = '0;
        trig_match  = '0;
        trig_store  = '0;
        trig_load   = '0;
        trig_tdata2 = '0;
        actionVec   = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            trig_select[i]         = tdata1_q[i][SELECT_B];
            trig_match[i]          = tdata1_q[i][MATCH_B];
            trig_store[i]          = tdata1_q[i][STORE_B] & tdata1_q[i][M_B];
            trig_load[i]           = tdata1_q[i][LOAD_B] & tdata1_q[i][M_B];
            trig_tdata2[32*i +: 32] = tdata2_q[i];
            actionVec[i]           = tdata1_q[i][ACTION_B];
        end
    end

    always_comb begin
        qualRaw = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            qualRaw[i] = lsu_trigger_match_dc3[i] & tdata1_q[i][M_B] & ~dbg_mode & idle;
        end
    end

    // Chaining is controlled by the even trigger of each pair; the odd trigger's chain bit is ignored.
    always_comb begin
        qual = qualRaw;
        for (int p = 0; p < NUM_TRIG; p += 2) begin
            if (tdata1_q[p][CHAIN_B]) begin
                qual[p]   = qualRaw[p] & qualRaw[p+1];
                qual[p+1] = qualRaw[p] & qualRaw[p+1];
            end
        end
    end

    assign commitRaw = dc5_q & {NUM_TRIG{idle & ~flush_dc5}};

`ifdef LSU_TRIG_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]    tcount_q [NUM_TRIG];
    logic [CNT_W-1:0]    tcount_d [NUM_TRIG];
    logic [NUM_TRIG-1:0] cntDec;

    // A count above one swallows the commit; reaching zero lets it through from then on.
    always_comb begin
        cntGate = '1;
        cntDec  = '0;
        for (int p = 0; p < NUM_TRIG; p += 2) begin
            if (tdata1_q[p][CHAIN_B]) begin
                if (commitRaw[p] | commitRaw[p+1]) begin
                    cntDec[p] = (tcount_q[p] != '0);
                    if (tcount_q[p] > CNT_ONE) begin
                        cntGate[p]   = 1'b0;
                        cntGate[p+1] = 1'b0;
                    end
                end
            end else begin
                for (int i = p; i < p + 2; i++) begin
                    if (commitRaw[i]) begin
                        cntDec[i] = (tcount_q[i] != '0);
                        if (tcount_q[i] > CNT_ONE) begin
                            cntGate[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            tcount_d[i] = tcount_q[i];
            if (cntDec[i]) begin
                tcount_d[i] = tcount_q[i] - CNT_ONE;
            end
            if (wrAllowed && csr_reg == 2'd2 && int'(csr_tsel) == i) begin
                tcount_d[i] = csr_wdata[CNT_W-1:0];
            end
            tcountView[i] = tcount_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_TRIG; i++) begin
                tcount_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TRIG; i++) begin
                tcount_q[i] <= tcount_d[i];
            end
        end
    end
`else
    always_comb begin
        cntGate = '1;
        for (int i = 0; i < NUM_TRIG; i++) begin
            tcountView[i] = '0;
        end
    end
`endif

    assign hitVec     = commitRaw & cntGate;
    assign haltCommit = |(hitVec & actionVec);

    assign trig_hit_dc5   = hitVec;
    assign trig_brkpt_dc5 = (|hitVec) & ~haltCommit;
    assign trig_halt_req  = haltReq_q;

    // The committed hit is OR'ed in after any same-cycle CSR write so it is never lost.
    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            tdata1_d[i] = tdata1_q[i];
            tdata2_d[i] = tdata2_q[i];
            if (wrAllowed && int'(csr_tsel) == i) begin
                if (csr_reg == 2'd0) begin
                    tdata1_d[i] = (csr_wdata & WR_MASK & ~DMODE_MASK)
                                | ((dbg_mode ? csr_wdata : tdata1_q[i]) & DMODE_MASK);
                end
                if (csr_reg == 2'd1) begin
                    tdata2_d[i] = csr_wdata;
                end
            end
            if (hitVec[i]) begin
                tdata1_d[i][HIT_B] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_TRIG; i++) begin
                tdata1_q[i] <= '0;
                tdata2_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_TRIG; i++) begin
                tdata1_q[i] <= tdata1_d[i];
                tdata2_q[i] <= tdata2_d[i];
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (csr_rd_en && int'(csr_tsel) == i) begin
                case (csr_reg)
                    2'd0:    csr_rdata = tdata1_q[i];
                    2'd1:    csr_rdata = tdata2_q[i];
                    2'd2:    csr_rdata = {{(32-CNT_W){1'b0}}, tcountView[i]};
                    default: csr_rdata = '0;
                endcase
            end
        end
    end

    // Leaving IDLE drops whatever is still in dc4/dc5; qualification is already blocked.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q   <= IDLE;
            haltReq_q <= 1'b0;
            dbgMode_q <= 1'b0;
            dc4_q     <= '0;
            dc5_q     <= '0;
        end else begin
            dbgMode_q <= dbg_mode;
            dc4_q     <= qual;
            dc5_q     <= (idle && !flush_dc4) ? dc4_q : '0;
            case (state_q)
                IDLE: begin
                    if (haltCommit) begin
                        state_q   <= HALT_REQ;
                        haltReq_q <= 1'b1;
                    end
                end
                HALT_REQ: begin
                    if (dbg_halt_ack) begin
                        state_q   <= HALTED;
                        haltReq_q <= 1'b0;
                    end
                end
                HALTED: begin
                    if (dbgMode_q && !dbg_mode) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    haltReq_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_trigger_ctl.sv
// Self-checking bench for lsu_trigger_ctl: directed scenarios plus a random phase against a
// cycle-indexed reference model (pending-hit queue keyed by due cycle).
module tb_lsu_trigger_ctl;
    logic         clk = 1'b0;
    logic         rst_l;
    logic         csr_wr_en, csr_rd_en;
    logic [1:0]   csr_tsel, csr_reg;
    logic [31:0]  csr_wdata;
    logic [31:0]  csr_rdata;
    logic         dbg_mode, dbg_halt_ack;
    logic [3:0]   match;
    logic         flush_dc4, flush_dc5;
    logic [3:0]   trig_select, trig_match, trig_store, trig_load;
    logic [127:0] trig_tdata2;
    logic [3:0]   trig_hit_dc5;
    logic         trig_brkpt_dc5, trig_halt_req;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] WMASK = 32'h0818_18C3;
    localparam logic [31:0] DMASK = 32'h0800_0000;

    typedef struct { int due; logic [3:0] vec; } pend_t;

    logic [31:0] mT1 [4];
    logic [31:0] mT2 [4];
    int unsigned mCnt [4];
    int          mState;
    bit          mDbgPrev;
    int          cyc;
    pend_t       pend[$];

    logic [31:0] lastRdata;
    logic [3:0]  lastHit;
    logic        lastBrk, lastHalt;

    lsu_trigger_ctl dut (
        .clk(clk), .rst_l(rst_l),
        .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en), .csr_tsel(csr_tsel), .csr_reg(csr_reg),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .dbg_mode(dbg_mode), .dbg_halt_ack(dbg_halt_ack),
        .lsu_trigger_match_dc3(match), .flush_dc4(flush_dc4), .flush_dc5(flush_dc5),
        .trig_select(trig_select), .trig_match(trig_match), .trig_store(trig_store),
        .trig_load(trig_load), .trig_tdata2(trig_tdata2), .trig_hit_dc5(trig_hit_dc5),
        .trig_brkpt_dc5(trig_brkpt_dc5), .trig_halt_req(trig_halt_req)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelRead(input int t, input int r);
        logic [31:0] v;
        v = '0;
        if (r == 0) v = mT1[t];
        if (r == 1) v = mT2[t];
`ifdef LSU_TRIG_COUNT_EN
        if (r == 2) v = 32'(mCnt[t]);
`endif
        return v;
    endfunction

    task automatic setIdle();
        csr_wr_en = 1'b0; csr_rd_en = 1'b0; csr_tsel = '0; csr_reg = '0; csr_wdata = '0;
        dbg_halt_ack = 1'b0; match = '0; flush_dc4 = 1'b0; flush_dc5 = 1'b0;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mT1[i] = '0; mT2[i] = '0; mCnt[i] = 0;
        end
        mState = 0; mDbgPrev = 1'b0; cyc = 0; pend = {};
    endtask

    task automatic applyReset();
        setIdle();
        dbg_mode = 1'b0;
        rst_l = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_l = 1'b1;
        modelReset();
    endtask

    // One clock cycle: predict from the model, compare at the negedge, advance the model at the posedge.
    task automatic applyStimulus();
        logic [3:0] raw, q, hExp, gate, hFin, dec, eSel, eMat, eSt, eLd;
        bit idle, haltNow;
        int t;
        pend_t keep[$];
        @(negedge clk);
        idle = (mState == 0);
        hExp = '0;
        keep = {};
        foreach (pend[k]) begin
            if (pend[k].due == cyc) begin
                if (idle && !flush_dc5) hExp |= pend[k].vec;
            end else if (!(pend[k].due == cyc + 1 && (flush_dc4 || !idle))) begin
                keep.push_back(pend[k]);
            end
        end
        pend = keep;
        for (int i = 0; i < 4; i++) raw[i] = match[i] && mT1[i][6] && !dbg_mode && idle;
        q = raw;
        for (int p = 0; p < 4; p += 2) begin
            if (mT1[p][11]) begin
                q[p] = raw[p] & raw[p+1];
                q[p+1] = q[p];
            end
        end
        if (q != '0) pend.push_back('{due: cyc + 2, vec: q});
        gate = '1;
        dec = '0;
`ifdef LSU_TRIG_COUNT_EN
        for (int p = 0; p < 4; p += 2) begin
            if (mT1[p][11]) begin
                if (hExp[p] || hExp[p+1]) begin
                    if (mCnt[p] > 1) begin gate[p] = 1'b0; gate[p+1] = 1'b0; end
                    if (mCnt[p] > 0) dec[p] = 1'b1;
                end
            end else begin
                for (int i = p; i < p + 2; i++) begin
                    if (hExp[i]) begin
                        if (mCnt[i] > 1) gate[i] = 1'b0;
                        if (mCnt[i] > 0) dec[i] = 1'b1;
                    end
                end
            end
        end
`endif
        hFin = hExp & gate;
        haltNow = 1'b0;
        for (int i = 0; i < 4; i++) if (hFin[i] && mT1[i][12]) haltNow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eSel[i] = mT1[i][19]; eMat[i] = mT1[i][7];
            eSt[i] = mT1[i][1] & mT1[i][6]; eLd[i] = mT1[i][0] & mT1[i][6];
        end
        lastRdata = csr_rdata; lastHit = trig_hit_dc5; lastBrk = trig_brkpt_dc5; lastHalt = trig_halt_req;
        checkOutput("hit_dc5", trig_hit_dc5, hFin);
        checkOutput("brkpt_dc5", trig_brkpt_dc5, (hFin != '0) && !haltNow);
        checkOutput("halt_req", trig_halt_req, mState == 1);
        checkOutput("cfg_out", {trig_select, trig_match, trig_store, trig_load}, {eSel, eMat, eSt, eLd});
        checkOutput("tdata2_out", trig_tdata2, {mT2[3], mT2[2], mT2[1], mT2[0]});
        if (csr_rd_en) checkOutput("csr_rdata", csr_rdata, modelRead(int'(csr_tsel), int'(csr_reg)));
        @(posedge clk);
        for (int i = 0; i < 4; i++) if (dec[i]) mCnt[i]--;
        t = int'(csr_tsel);
        if (csr_wr_en && !(mT1[t][27] && !dbg_mode)) begin
            if (csr_reg == 2'd0) mT1[t] = (csr_wdata & WMASK & ~DMASK) | ((dbg_mode ? csr_wdata : mT1[t]) & DMASK);
            if (csr_reg == 2'd1) mT2[t] = csr_wdata;
`ifdef LSU_TRIG_COUNT_EN
            if (csr_reg == 2'd2) mCnt[t] = int'(csr_wdata[7:0]);
`endif
        end
        for (int i = 0; i < 4; i++) if (hFin[i]) mT1[i][20] = 1'b1;
        if (mState == 0 && haltNow) mState = 1;
        else if (mState == 1 && dbg_halt_ack) mState = 2;
        else if (mState == 2 && mDbgPrev && !dbg_mode) mState = 0;
        mDbgPrev = dbg_mode;
        cyc++;
        #1;
    endtask

    task automatic csrWrite(input int t, input int r, input logic [31:0] d);
        csr_wr_en = 1'b1; csr_tsel = 2'(t); csr_reg = 2'(r); csr_wdata = d;
        applyStimulus();
        csr_wr_en = 1'b0;
    endtask

    task automatic csrRead(input int t, input int r);
        csr_rd_en = 1'b1; csr_tsel = 2'(t); csr_reg = 2'(r);
        applyStimulus();
        csr_rd_en = 1'b0;
    endtask

    task automatic matchOnce(input logic [3:0] v);
        match = v;
        applyStimulus();
        match = '0;
    endtask

    // Match issued in the previous call; this returns on the cycle it should reach dc5.
    task automatic waitDc5();
        applyStimulus();
        applyStimulus();
    endtask

    initial begin
        rst_l = 1'b0;
        dbg_mode = 1'b0;
        setIdle();
        applyReset();

        applyStimulus();
        checkOutput("reset_hit", lastHit, 4'b0000);
        checkOutput("reset_halt", lastHalt, 1'b0);
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < 3; r++) begin
                csrRead(t, r);
                checkOutput($sformatf("reset_rd_t%0d_r%0d", t, r), lastRdata, 32'h0);
            end
        end

        csrWrite(0, 0, 32'h0000_0042);
        csrWrite(0, 1, 32'h0000_1000);
        matchOnce(4'b0001);
        waitDc5();
        checkOutput("basic_hit", lastHit, 4'b0001);
        checkOutput("basic_brkpt", lastBrk, 1'b1);
        csrRead(0, 0);
        checkOutput("basic_hitbit", lastRdata, 32'h0010_0042);

        csrWrite(0, 0, 32'h0000_0842);
        csrWrite(1, 0, 32'h0000_0041);
        matchOnce(4'b0001);
        waitDc5();
        checkOutput("chain_half", lastHit, 4'b0000);
        matchOnce(4'b0011);
        waitDc5();
        checkOutput("chain_both", lastHit, 4'b0011);

        csrWrite(0, 0, 32'h0);
        csrWrite(1, 0, 32'h0);
        csrWrite(2, 0, 32'h0000_1041);
        matchOnce(4'b0100);
        waitDc5();
        checkOutput("halt_hit", lastHit, 4'b0100);
        checkOutput("halt_nobrk", lastBrk, 1'b0);
        applyStimulus();
        checkOutput("halt_req_set", lastHalt, 1'b1);
        matchOnce(4'b0100);
        waitDc5();
        checkOutput("halt_blocked", lastHit, 4'b0000);
        dbg_halt_ack = 1'b1;
        applyStimulus();
        dbg_halt_ack = 1'b0;
        dbg_mode = 1'b1;
        applyStimulus();
        checkOutput("halt_req_drop", lastHalt, 1'b0);
        applyStimulus();
        dbg_mode = 1'b0;
        applyStimulus();
        matchOnce(4'b0100);
        waitDc5();
        checkOutput("resume_hit", lastHit, 4'b0100);
        applyStimulus();
        dbg_halt_ack = 1'b1;
        applyStimulus();
        dbg_halt_ack = 1'b0;
        dbg_mode = 1'b1;
        applyStimulus();
        dbg_mode = 1'b0;
        applyStimulus();

        csrWrite(2, 0, 32'h0);
        csrWrite(3, 0, 32'h0000_0042);
        matchOnce(4'b1000);
        flush_dc4 = 1'b1;
        applyStimulus();
        flush_dc4 = 1'b0;
        applyStimulus();
        checkOutput("flush4_hit", lastHit, 4'b0000);
        csrRead(3, 0);
        checkOutput("flush4_bit", lastRdata, 32'h0000_0042);
        matchOnce(4'b1000);
        applyStimulus();
        flush_dc5 = 1'b1;
        applyStimulus();
        flush_dc5 = 1'b0;
        checkOutput("flush5_hit", lastHit, 4'b0000);
        csrRead(3, 0);
        checkOutput("flush5_bit", lastRdata, 32'h0000_0042);

`ifdef LSU_TRIG_COUNT_EN
        csrWrite(1, 0, 32'h0000_0041);
        csrWrite(1, 2, 32'd3);
        for (int n = 0; n < 3; n++) begin
            matchOnce(4'b0010);
            waitDc5();
            checkOutput($sformatf("count_m%0d", n), lastHit, (n == 2) ? 4'b0010 : 4'b0000);
        end
        csrRead(1, 2);
        checkOutput("count_zero", lastRdata, 32'h0);
        matchOnce(4'b0010);
        waitDc5();
        checkOutput("count_free", lastHit, 4'b0010);
`endif

        for (int n = 0; n < 400; n++) begin
            setIdle();
            if (n == 200) applyReset();
            if ($urandom_range(0, 3) == 0) begin
                csr_wr_en = 1'b1;
                csr_tsel = 2'($urandom_range(0, 3));
                csr_reg = 2'($urandom_range(0, 3));
                csr_wdata = $urandom;
                if (csr_reg == 2'd0) begin
                    csr_wdata[6] = ($urandom_range(0, 3) != 0);
                    csr_wdata[12] = ($urandom_range(0, 3) == 0);
                end
                if (csr_reg == 2'd2) csr_wdata[7:0] = 8'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 0) begin
                csr_rd_en = 1'b1;
                csr_tsel = 2'($urandom_range(0, 3));
                csr_reg = 2'($urandom_range(0, 3));
            end
            match = 4'($urandom);
            flush_dc4 = ($urandom_range(0, 7) == 0);
            flush_dc5 = ($urandom_range(0, 7) == 0);
            dbg_halt_ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 11) == 0) dbg_mode = ~dbg_mode;
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
